// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: round-robin arbiter for two command requesters, a small
// command FIFO, and an issue FSM that talks to the LCD image controller
// over cmd/cmd_valid/busy. A write command (0) closes intake, and the
// scheduler locks once the controller reports done.
module lcd_cmd_sched #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   input  logic [3:0]       a_cmd,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [3:0]       b_cmd,
   output logic             b_ready,
   input  logic             busy,
   input  logic             done,
   output logic [3:0]       cmd,
   output logic             cmd_valid,
   output logic [CNT_W-1:0] fifo_count,
   output logic             err_invalid,
   output logic             sched_done
);

   localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_FREE,
      S_FLUSH,
      S_END
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             prio_b;
   logic             closed;
   logic             ack_cnt;
   logic             full, eligible, grant_b, accept, push, drop, pop;
   logic [3:0]       acc_cmd, head;

   // Full is judged on the registered count, so a same-cycle pop never
   // frees a slot early.
   assign full       = (count == FULL_CNT);
   assign eligible   = !full && !closed;
   assign grant_b    = b_valid && (!a_valid || prio_b);
   assign a_ready    = eligible && a_valid && !grant_b;
   assign b_ready    = eligible && grant_b;
   assign accept     = a_ready || b_ready;
   assign acc_cmd    = grant_b ? b_cmd : a_cmd;
   assign push       = accept && (acc_cmd < 4'd12);
   assign drop       = accept && (acc_cmd >= 4'd12);
   assign head       = mem[rd_ptr];
   assign fifo_count = count;

   // Command storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= acc_cmd;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // Priority pointer toggles on every accept; intake closes after a write command.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_b      <= 1'b0;
         closed      <= 1'b0;
         err_invalid <= 1'b0;
      end else begin
         if (accept) prio_b <= !prio_b;
         if (accept && acc_cmd == 4'd0) closed <= 1'b1;
         err_invalid <= drop;
      end
   end

   // Issue FSM state, held command, ack timeout and sticky completion flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cmd        <= 4'd0;
         ack_cnt    <= 1'b0;
         sched_done <= 1'b0;
      end else begin
         state   <= state_nxt;
         ack_cnt <= (state == S_WAIT_ACK);
         if (state == S_IDLE && state_nxt == S_ISSUE) cmd <= head;
         if (state == S_FLUSH && done) sched_done <= 1'b1;
      end
   end

   // Next-state and strobe decode; ISSUE is the only single-cycle state.
   always_comb begin
      state_nxt = state;
      cmd_valid = 1'b0;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != '0 && !busy) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            cmd_valid = 1'b1;
            pop       = 1'b1;
            state_nxt = (cmd == 4'd0) ? S_FLUSH : S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (busy)         state_nxt = S_WAIT_FREE;
            else if (ack_cnt) state_nxt = S_IDLE;
         end
         S_WAIT_FREE: begin
            if (!busy) state_nxt = S_IDLE;
         end
         S_FLUSH: begin
            if (done) state_nxt = S_END;
         end
         S_END: begin
            state_nxt = S_END;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Bench for lcd_cmd_sched: a small controller model raises busy the cycle
// after each issue strobe; expected issues are queued at acceptance and
// compared against the recorded issue stream.
`timescale 1ns/1ps
module tb_lcd_cmd_sched;

   localparam int DEPTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             a_valid = 1'b0, b_valid = 1'b0;
   logic [3:0]       a_cmd = 4'd0, b_cmd = 4'd0;
   logic             a_ready, b_ready;
   logic             busy;
   logic             done = 1'b0;
   logic [3:0]       cmd;
   logic             cmd_valid;
   logic [CNT_W-1:0] fifo_count;
   logic             err_invalid, sched_done;

   logic force_busy = 1'b0;
   logic ack_en = 1'b0;
   logic ack_busy = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int exp_q[$];
   int iss_q[$];
   int iss_t[$];
   int acc_side[$];
   int acc_t[$];
   int err_cnt = 0;
   bit consec = 1'b0;
   bit prev_cv = 1'b0;

   lcd_cmd_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_cmd(a_cmd), .a_ready(a_ready),
      .b_valid(b_valid), .b_cmd(b_cmd), .b_ready(b_ready),
      .busy(busy), .done(done),
      .cmd(cmd), .cmd_valid(cmd_valid), .fifo_count(fifo_count),
      .err_invalid(err_invalid), .sched_done(sched_done)
   );

   always #5 clk = ~clk;

   assign busy = force_busy | ack_busy;
   always @(posedge clk) ack_busy <= ack_en & cmd_valid;

   // Record what happened at each rising edge (pre-update values).
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!reset) begin
         if (a_valid && a_ready) begin acc_side.push_back(0); acc_t.push_back(cyc); end
         if (b_valid && b_ready) begin acc_side.push_back(1); acc_t.push_back(cyc); end
         if (cmd_valid) begin iss_q.push_back(int'(cmd)); iss_t.push_back(cyc); end
         if (err_invalid) err_cnt++;
         if (cmd_valid && prev_cv) consec = 1'b1;
      end
      prev_cv = cmd_valid;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_sb();
      exp_q.delete(); iss_q.delete(); iss_t.delete();
      acc_side.delete(); acc_t.delete();
      err_cnt = 0; consec = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_cmd = 4'd0; b_cmd = 4'd0;
      done = 1'b0; force_busy = 1'b0; ack_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      clear_sb();
   endtask

   task automatic push_cmd(input bit side, input logic [3:0] c, input int budget, output bit ok);
      ok = 1'b0;
      if (side) begin b_valid = 1'b1; b_cmd = c; end
      else begin a_valid = 1'b1; a_cmd = c; end
      for (int i = 0; i < budget && !ok; i++) begin
         #1;
         if ((side ? b_ready : a_ready) === 1'b1) begin
            ok = 1'b1;
            if (c < 4'd12) exp_q.push_back(int'(c));
         end
         @(negedge clk);
      end
      if (side) b_valid = 1'b0;
      else a_valid = 1'b0;
   endtask

   task automatic wait_issues(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (iss_q.size() >= n) ok = 1'b1;
         else @(negedge clk);
      end
      if (iss_q.size() >= n) ok = 1'b1;
   endtask

   task automatic test_reset();
      bit ok;
      int e, g;
      do_reset();
      #1;
      checks++;
      if (cmd_valid !== 1'b0 || cmd !== 4'd0 || fifo_count !== '0 || err_invalid !== 1'b0 || sched_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: cmd_valid=%0b cmd=%0d count=%0d err=%0b sdone=%0b, required all 0",
                  cmd_valid, cmd, fifo_count, err_invalid, sched_done);
      end
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: a_ready=%0b b_ready=%0b, required 0 0", a_ready, b_ready);
      end
      @(negedge clk);
      push_cmd(1'b0, 4'd6, 4, ok);
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL latency_accept: accepted=%0b required 1", ok); end
      wait_issues(1, 10, ok);
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL latency_issue: issued=%0d required 1", iss_q.size()); end
      if (ok && acc_t.size() > 0) begin
         checks++;
         if (iss_t[0] - acc_t[0] != 2) begin
            failures++;
            $display("FAIL latency_cycles: got %0d required 2", iss_t[0] - acc_t[0]);
         end
         e = -1; g = -1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         if (iss_q.size() > 0) g = iss_q.pop_front();
         checks++;
         if (g != e) begin failures++; $display("FAIL latency_cmd: got %0d required %0d", g, e); end
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_busy_load();
      bit ok, all_ok;
      int e, g;
      do_reset();
      force_busy = 1'b1;
      all_ok = 1'b1;
      for (int v = 1; v <= 3; v++) begin
         push_cmd(1'b0, 4'(v), 4, ok);
         all_ok &= ok;
      end
      checks++;
      if (all_ok !== 1'b1) begin failures++; $display("FAIL load_accept: all accepted=%0b required 1", all_ok); end
      repeat (60) @(negedge clk);
      #1;
      checks++;
      if (fifo_count !== 4'd3) begin failures++; $display("FAIL load_count: got %0d required 3", fifo_count); end
      checks++;
      if (iss_q.size() != 0) begin failures++; $display("FAIL load_no_issue: issued %0d required 0", iss_q.size()); end
      @(negedge clk);
      force_busy = 1'b0;
      wait_issues(3, 40, ok);
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL load_issue_count: got %0d required 3", iss_q.size()); end
      if (iss_t.size() >= 3) begin
         checks++;
         if (iss_t[1] - iss_t[0] != 4 || iss_t[2] - iss_t[1] != 4) begin
            failures++;
            $display("FAIL load_spacing: got %0d,%0d required 4,4", iss_t[1] - iss_t[0], iss_t[2] - iss_t[1]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         e = -1; g = -1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         if (iss_q.size() > 0) g = iss_q.pop_front();
         checks++;
         if (g != e) begin failures++; $display("FAIL load_order[%0d]: got %0d required %0d", i, g, e); end
      end
      checks++;
      if (consec !== 1'b0) begin failures++; $display("FAIL load_single_strobe: consecutive=%0b required 0", consec); end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_round_robin();
      bit ok, both_bad;
      int nacc, e, g;
      do_reset();
      nacc = 0; both_bad = 1'b0;
      a_valid = 1'b1; a_cmd = 4'd4; b_valid = 1'b1; b_cmd = 4'd5;
      for (int i = 0; i < 20 && nacc < 6; i++) begin
         #1;
         if (a_ready && b_ready) both_bad = 1'b1;
         if (a_ready) begin exp_q.push_back(4); nacc++; end
         else if (b_ready) begin exp_q.push_back(5); nacc++; end
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      checks++;
      if (nacc != 6) begin failures++; $display("FAIL rr_accepts: got %0d required 6", nacc); end
      checks++;
      if (both_bad !== 1'b0) begin failures++; $display("FAIL rr_onehot: both ready=%0b required 0", both_bad); end
      for (int i = 0; i < 6; i++) begin
         g = -1;
         if (acc_side.size() > i) g = acc_side[i];
         checks++;
         if (g != i % 2) begin failures++; $display("FAIL rr_side[%0d]: got %0d required %0d", i, g, i % 2); end
      end
      wait_issues(6, 60, ok);
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL rr_issue_count: got %0d required 6", iss_q.size()); end
      for (int i = 0; i < 6; i++) begin
         e = -1; g = -1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         if (iss_q.size() > 0) g = iss_q.pop_front();
         checks++;
         if (g != e || g != ((i % 2) ? 5 : 4)) begin
            failures++;
            $display("FAIL rr_stream[%0d]: got %0d required %0d", i, g, (i % 2) ? 5 : 4);
         end
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_full_stall();
      bit ok, all_ok, got;
      int e, g;
      do_reset();
      force_busy = 1'b1;
      all_ok = 1'b1;
      for (int v = 1; v <= 8; v++) begin
         push_cmd(1'b0, 4'(v), 4, ok);
         all_ok &= ok;
      end
      checks++;
      if (all_ok !== 1'b1) begin failures++; $display("FAIL full_fill: all accepted=%0b required 1", all_ok); end
      a_valid = 1'b1; a_cmd = 4'd9;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (a_ready !== 1'b0 || fifo_count !== 4'd8) begin
         failures++;
         $display("FAIL full_stall: a_ready=%0b count=%0d, required 0 8", a_ready, fifo_count);
      end
      @(negedge clk);
      force_busy = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (a_ready === 1'b1) begin got = 1'b1; exp_q.push_back(9); end
         @(negedge clk);
      end
      a_valid = 1'b0;
      checks++;
      if (got !== 1'b1) begin failures++; $display("FAIL full_ninth_accept: accepted=%0b required 1", got); end
      if (acc_t.size() >= 9 && iss_t.size() >= 1) begin
         checks++;
         if (acc_t[8] != iss_t[0] + 1) begin
            failures++;
            $display("FAIL full_ninth_timing: accepted %0d cycles after first pop, required 1", acc_t[8] - iss_t[0]);
         end
      end
      wait_issues(9, 80, ok);
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL full_issue_count: got %0d required 9", iss_q.size()); end
      for (int i = 0; i < 9; i++) begin
         e = -1; g = -1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         if (iss_q.size() > 0) g = iss_q.pop_front();
         checks++;
         if (g != e) begin failures++; $display("FAIL full_order[%0d]: got %0d required %0d", i, g, e); end
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_invalid();
      bit ok;
      int e, g;
      do_reset();
      push_cmd(1'b1, 4'd13, 4, ok);
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL inv_b_ready: accepted=%0b required 1", ok); end
      #1;
      checks++;
      if (err_invalid !== 1'b1) begin failures++; $display("FAIL inv_err_pulse: got %0b required 1", err_invalid); end
      @(negedge clk);
      #1;
      checks++;
      if (err_invalid !== 1'b0) begin failures++; $display("FAIL inv_err_width: got %0b required 0", err_invalid); end
      checks++;
      if (fifo_count !== 4'd0) begin failures++; $display("FAIL inv_count: got %0d required 0", fifo_count); end
      repeat (8) @(negedge clk);
      checks++;
      if (iss_q.size() != 0) begin failures++; $display("FAIL inv_no_issue: issued %0d required 0", iss_q.size()); end
      checks++;
      if (err_cnt != 1) begin failures++; $display("FAIL inv_err_count: got %0d required 1", err_cnt); end
      push_cmd(1'b0, 4'd3, 4, ok);
      wait_issues(1, 10, ok);
      e = -1; g = -1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (iss_q.size() > 0) g = iss_q.pop_front();
      checks++;
      if (g != e || g != 3) begin failures++; $display("FAIL inv_next_cmd: got %0d required 3", g); end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_terminal();
      bit ok1, ok2, ok, seen;
      int e, g;
      do_reset();
      push_cmd(1'b0, 4'd7, 4, ok1);
      push_cmd(1'b0, 4'd0, 4, ok2);
      checks++;
      if ((ok1 && ok2) !== 1'b1) begin failures++; $display("FAIL term_accept: accepted=%0b%0b required 11", ok1, ok2); end
      a_valid = 1'b1; a_cmd = 4'd2; b_valid = 1'b1; b_cmd = 4'd2;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (a_ready || b_ready) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) begin failures++; $display("FAIL term_closed: ready seen=%0b required 0", seen); end
      wait_issues(2, 30, ok);
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL term_issue_count: got %0d required 2", iss_q.size()); end
      for (int i = 0; i < 2; i++) begin
         e = -1; g = -1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         if (iss_q.size() > 0) g = iss_q.pop_front();
         checks++;
         if (g != e) begin failures++; $display("FAIL term_order[%0d]: got %0d required %0d", i, g, e); end
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (sched_done !== 1'b0) begin failures++; $display("FAIL term_wait_done: sched_done=%0b required 0", sched_done); end
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      #1;
      checks++;
      if (sched_done !== 1'b1) begin failures++; $display("FAIL term_done_set: sched_done=%0b required 1", sched_done); end
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if (sched_done !== 1'b1 || a_ready !== 1'b0 || iss_q.size() != 0) begin
         failures++;
         $display("FAIL term_locked: sched_done=%0b a_ready=%0b extra_issues=%0d, required 1 0 0",
                  sched_done, a_ready, iss_q.size());
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_mid_reset();
      bit ok, all_ok;
      int e, g;
      do_reset();
      force_busy = 1'b1;
      all_ok = 1'b1;
      for (int v = 1; v <= 4; v++) begin
         push_cmd(1'b0, 4'(v), 4, ok);
         all_ok &= ok;
      end
      push_cmd(1'b0, 4'd13, 4, ok);
      all_ok &= ok;
      checks++;
      if (all_ok !== 1'b1) begin failures++; $display("FAIL mid_fill: all accepted=%0b required 1", all_ok); end
      @(negedge clk);
      force_busy = 1'b0;
      wait_issues(1, 10, ok);
      force_busy = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (fifo_count !== 4'd3) begin failures++; $display("FAIL mid_precount: got %0d required 3", fifo_count); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      force_busy = 1'b0;
      clear_sb();
      #1;
      checks++;
      if (fifo_count !== 4'd0 || cmd_valid !== 1'b0 || sched_done !== 1'b0) begin
         failures++;
         $display("FAIL mid_cleared: count=%0d cmd_valid=%0b sdone=%0b, required 0 0 0", fifo_count, cmd_valid, sched_done);
      end
      a_valid = 1'b1; a_cmd = 4'd6; b_valid = 1'b1; b_cmd = 4'd8;
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_pointer: a_ready=%0b b_ready=%0b, required 1 0", a_ready, b_ready);
      end
      if (a_ready === 1'b1) exp_q.push_back(6);
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      wait_issues(1, 10, ok);
      e = -1; g = -1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (iss_q.size() > 0) g = iss_q.pop_front();
      checks++;
      if (g != e || g != 6) begin failures++; $display("FAIL mid_after_cmd: got %0d required 6", g); end
      repeat (6) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_busy_load();
      test_round_robin();
      test_full_stall();
      test_invalid();
      test_terminal();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_cmd_sched.md
# lcd_cmd_sched

Command scheduler in front of the LCD image controller. It accepts 4-bit LCD commands from two independent requesters (A, B) and arbitrates between them round-robin. Accepted commands are queued in a small FIFO and issued one at a time over the controller's `cmd`/`cmd_valid`/`busy` handshake. After the terminal write command (cmd 0) is issued, it waits for the controller's `done` and then locks.

## Interface
- DEPTH, 8: FIFO entries (power of two, 2–16)
- CNT_W, 4: width of `fifo_count` (must hold DEPTH)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- a_valid / b_valid  in  1  requester has a command
- a_cmd / b_cmd  in  4  requester command
- a_ready / b_ready  out  1  command accepted this cycle (valid & ready)
- busy  in  1  controller busy (from LCD controller)
- done  in  1  controller write-out finished
- cmd  out  4  command to controller
- cmd_valid  out  1  one-cycle issue strobe
- fifo_count  out  CNT_W  queued entries
- err_invalid  out  1  one-cycle pulse: dropped illegal command
- sched_done  out  1  sticky: terminal write completed

## Operation
- Reset: all outputs 0, FIFO empty, priority pointer = A, `closed` = 0, FSM = IDLE.
- Arbitration, combinational:
  - eligible = !full & !closed.
  - With only one valid requester, that requester is granted. With both valid, the priority-pointer side is granted.
  - Grant ready = eligible & valid of the granted side. Exactly one ready is high at a time.
  - The pointer flips to the other side after every accepted transfer, regardless of which side was granted.
- Enqueue on acceptance:
  - cmd 0–11 is pushed.
  - cmd 12–15 is accepted but dropped, and `err_invalid` is high in the next cycle.
  - When cmd 0 is accepted, `closed` is set. Both readys then stay 0 until reset.
- `full` uses the count before any same-cycle pop. A push and a pop in the same cycle leave the count unchanged.
- FSM:
  - IDLE: if FIFO non-empty & busy==0, go to ISSUE.
  - ISSUE: drive `cmd_valid`=1 and `cmd`=head for exactly one cycle, and pop the head. If the head is 0, go to FLUSH; otherwise go to WAIT_ACK.
  - WAIT_ACK: wait for busy==1, then go to WAIT_FREE. If busy is still 0 after 2 cycles, treat the command as completed and go to IDLE.
  - WAIT_FREE: wait for busy==0, then go to IDLE.
  - FLUSH: wait for done==1, then set `sched_done` and go to END.
  - END: absorbing state. No further issue; the FIFO is ignored.
- `cmd` holds its last value when `cmd_valid`=0 and is 0 after reset.
- Mid-operation reset clears the FIFO, `closed`, and `sched_done` in the same cycle; `cmd_valid` is 0 in the following cycle.

## Timing
- Queue latency: a command accepted at edge N into an empty FIFO with busy==0 and the FSM in IDLE appears with `cmd_valid` in cycle N+2. Cycle N+1 is the IDLE→ISSUE decision; N+2 is ISSUE.
- Back-to-back issue:
  - Against a controller that drops busy one cycle after its busy pulse, the issue-to-issue spacing is 4 cycles (ISSUE, WAIT_ACK, WAIT_FREE, IDLE).
  - `cmd_valid` is never high on two consecutive cycles.
- Busy high during the controller's initial 64-cycle image load holds the FSM in IDLE. Commands still enqueue during this time up to DEPTH.
- `fifo_count` is registered and reflects pushes and pops of the previous edge.
- `err_invalid` is registered: one pulse per dropped command.

## Test plan
- Reset, then busy=1 for 64 cycles while A pushes 1,2,3 → all three are accepted and `fifo_count`=3 with no `cmd_valid`. Busy drops → cmds 1,2,3 are issued in order, spaced ≥4 cycles, each held exactly one cycle.
- A and B both valid continuously with cmds 4 and 5, busy=0, controller model acknowledging → accepted sequence alternates A,B,A,B starting with A; the issued stream is 4,5,4,5.
- Hold busy=1, push 9 commands → the 9th is stalled (ready=0 while `fifo_count`=8). Release busy → the 9th is accepted on the cycle after the first pop.
- Push cmd 13 from B → `b_ready`=1, then `err_invalid`=1 for one cycle; `fifo_count` unchanged, and 13 is never issued.
- Push 7 then 0, then try a further push of 2 → ready stays 0 after the 0 is accepted. Issue order is 7, then 0. `sched_done` stays 0 until `done` is pulsed, then goes to 1 and stays sticky.
- Assert reset while in WAIT_FREE with 3 entries queued → next cycle `fifo_count`=0, `cmd_valid`=0, readys re-enabled, and the priority pointer is back to A.
